data_access_unit: RTL and testbench
===================================

Name: data_access_unit

Overview:
- Sequences every memory-stage data access onto the shared 256-bit synchronous data RAM.
- Sits directly downstream of the memory stage. It consumes MemRden, MemWren, MemAddress, MemByteena and MemWriteData, and returns BusyDA and MemReadData.
- BusyDA stalls the pipeline through the hazard unit. Read data is registered and held stable for the memory stage.

Parameters:
- V, 256, data line width in bits.
- AW, 14, MemAddress width in bits, byte address.
- LW, 9, RAM line-index width; the line index is MemAddress[AW-1:5].
- RD_LAT, 2, RAM read latency in cycles from the ram_rden cycle to valid ram_q; legal range 1..3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRden  in  1  read request from the memory stage.
- MemWren  in  1  write request from the memory stage.
- MemAddress  in  AW  byte address; bits [4:0] are ignored because lane selection comes from MemByteena.
- MemByteena  in  V/8  byte-lane enable mask for writes.
- MemWriteData  in  V  write line, already lane-aligned.
- BusyDA  out  1  access in progress; stall request to the hazard unit.
- MemReadData  out  V  registered read line.
- ram_address  out  LW  RAM line index.
- ram_rden  out  1  RAM read strobe.
- ram_wren  out  1  RAM write strobe.
- ram_byteena  out  V/8  RAM byte enables.
- ram_data  out  V  RAM write data.
- ram_q  in  V  RAM read data.

Behaviour:
- Only one clock domain (clk). rst is synchronous and active-high.
- Reset forces:
  - state to IDLE and the latency counter to 0;
  - BusyDA=0, ram_rden=0, ram_wren=0;
  - ram_address, ram_byteena, ram_data and MemReadData to all zeros.
- State machine states: IDLE, WRITE, READ, WAIT, DONE.
- A request is accepted only in IDLE.
  - In IDLE, acceptance latches MemAddress[AW-1:5], MemByteena and MemWriteData into the ram_* output registers.
  - If both MemRden and MemWren are high, the write wins and the read is dropped.
- BusyDA is combinational: 1 when (IDLE and (MemRden or MemWren)), or when the state is WRITE, READ or WAIT. It is 0 in DONE and in idle IDLE. The stalled stage therefore freezes from the first request cycle.
- IDLE transitions: to WRITE if MemWren, else to READ if MemRden, else stay in IDLE.
- WRITE: ram_wren=1 for exactly one cycle with the latched address, byte enables and data; next state DONE. Total stall is 2 cycles.
- READ:
  - ram_rden=1 for exactly one cycle; ram_byteena is driven all-ones.
  - The latency counter loads 1; next state WAIT.
- WAIT:
  - The counter increments each cycle.
  - When the counter equals RD_LAT, ram_q is captured into MemReadData on that edge and the next state is DONE. Otherwise the state stays WAIT.
  - Total stall is RD_LAT+2 cycles, counting the IDLE request cycle.
- DONE:
  - BusyDA=0 and no request is accepted. The stalled memory-stage instruction advances at the end of this cycle with MemReadData valid.
  - Next state IDLE.
  - DONE exists so that the still-asserted request of the completing instruction is never re-accepted.
- MemReadData holds its value until the next read capture; writes never modify it.
- ram_rden and ram_wren are never high in the same cycle, and each is never high for more than one consecutive cycle per access.
- A write with MemByteena=0 still runs the WRITE cycle, with the RAM left unchanged.
- Reset mid-access (in WRITE, READ or WAIT):
  - the strobes drop on the next edge and the state returns to IDLE;
  - a pending read capture is discarded and MemReadData is cleared.
- Back-to-back accesses: a request present in the first IDLE cycle after DONE is accepted normally, so there is one non-busy cycle between accesses.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, then no requests -> BusyDA=0, ram_rden=ram_wren=0, MemReadData=0 in every cycle.
- Full write: MemWren=1, MemAddress=14'h0040, MemByteena=32'hFFFFFFFF, MemWriteData=256'h00..0F0E...01 (ascending bytes) ->
  - BusyDA=1 for 2 cycles;
  - one ram_wren pulse with ram_address=9'h002 and the data unchanged;
  - BusyDA=0 in the DONE cycle.
- Read with RD_LAT=2: RAM model returns a line of 32'hA5A5A5A5 repeated for line 9'h002; MemRden=1, MemAddress=14'h0040 ->
  - BusyDA high for 4 cycles;
  - a single ram_rden pulse;
  - MemReadData equals that line in the DONE cycle, and holds it after MemRden drops.
- Partial write then read: write MemByteena=32'h0000000F, data 32'hDEADBEEF in the low word, to line 3; then read line 3 -> low word 32'hDEADBEEF, all other bytes keep their prior value; exactly one ram_wren and one ram_rden pulse.
- Simultaneous MemRden=MemWren=1 -> only a WRITE sequence occurs (ram_rden stays 0), and MemReadData is unchanged.
- Reset during WAIT: assert rst for 1 cycle while in WAIT -> next cycle state IDLE, BusyDA=0 unless a new request is present, MemReadData=0, no late capture of ram_q.

Source files
------------

// File: rtl/data_access_unit.sv
// rtl/data_access_unit.sv - sequences memory-stage accesses onto the shared data RAM
//
// Purpose: accepts one read or write request at a time from the memory stage.
// It drives the synchronous line-wide data RAM and stalls the pipeline with
// BusyDA until the access completes. Read data is registered and is held
// until the next read.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   MemRden/MemWren   read/write request (write wins if both are set)
//   MemAddress        byte address, line index taken from [AW-1:5]
//   MemByteena        byte-lane write mask
//   MemWriteData      lane-aligned write line
//   BusyDA            stall request to the hazard unit (combinational)
//   MemReadData       registered read line
//   ram_*             RAM address, strobes, byte enables, write data, read data
module data_access_unit #(
  parameter int V      = 256,
  parameter int AW     = 14,
  parameter int LW     = 9,
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemRden,
  input  logic            MemWren,
  input  logic [AW-1:0]   MemAddress,
  input  logic [V/8-1:0]  MemByteena,
  input  logic [V-1:0]    MemWriteData,
  output logic            BusyDA,
  output logic [V-1:0]    MemReadData,
  output logic [LW-1:0]   ram_address,
  output logic            ram_rden,
  output logic            ram_wren,
  output logic [V/8-1:0]  ram_byteena,
  output logic [V-1:0]    ram_data,
  input  logic [V-1:0]    ram_q
);

  localparam int BW = V / 8;
  localparam logic [1:0] RD_LAT_C = RD_LAT[1:0];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [LW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   be_q, be_d;
  logic [V-1:0]    wdata_q, wdata_d;
  logic [V-1:0]    rdata_q, rdata_d;
  logic            accept;

  // Lane selection comes from the byte mask, so the low address bits carry
  // nothing for this unit.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, MemAddress[4:0]};

  assign accept = (state_q == ST_IDLE) && (MemRden || MemWren);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = MemAddress[AW-1:5];
          be_d    = MemByteena;
          wdata_d = MemWriteData;
          state_d = MemWren ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_READ: begin
        cnt_d   = 2'd1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // cnt_q counts cycles since the rden edge; ram_q is valid once it
        // reaches the RAM latency.
        if (cnt_q == RD_LAT_C) begin
          rdata_d = ram_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      // DONE swallows the completing instruction's still-asserted request.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign BusyDA      = accept || (state_q == ST_WRITE) || (state_q == ST_READ)
                       || (state_q == ST_WAIT);
  assign ram_wren    = (state_q == ST_WRITE);
  assign ram_rden    = (state_q == ST_READ);
  assign ram_byteena = ram_rden ? {BW{1'b1}} : be_q;
  assign ram_address = addr_q;
  assign ram_data    = wdata_q;
  assign MemReadData = rdata_q;

endmodule

// File: tb/tb_data_access_unit.sv
// tb/tb_data_access_unit.sv - self-checking bench for data_access_unit
module tb_data_access_unit;

  localparam int V      = 256;
  localparam int AW     = 14;
  localparam int LW     = 9;
  localparam int BW     = V / 8;
  localparam int RD_LAT = 2;
  localparam int NLINES = 1 << LW;

  logic            clk = 1'b0;
  logic            rst;
  logic            MemRden, MemWren;
  logic [AW-1:0]   MemAddress;
  logic [BW-1:0]   MemByteena;
  logic [V-1:0]    MemWriteData;
  logic            BusyDA;
  logic [V-1:0]    MemReadData;
  logic [LW-1:0]   ram_address;
  logic            ram_rden, ram_wren;
  logic [BW-1:0]   ram_byteena;
  logic [V-1:0]    ram_data;
  logic [V-1:0]    ram_q;

  always #5 clk = ~clk;

  data_access_unit #(.V(V), .AW(AW), .LW(LW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .MemRden(MemRden), .MemWren(MemWren), .MemAddress(MemAddress),
    .MemByteena(MemByteena), .MemWriteData(MemWriteData),
    .BusyDA(BusyDA), .MemReadData(MemReadData),
    .ram_address(ram_address), .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_byteena(ram_byteena), .ram_data(ram_data), .ram_q(ram_q)
  );

  function automatic logic [V-1:0] rand_line();
    logic [V-1:0] l;
    for (int i = 0; i < V / 32; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [V-1:0] init_line(input int idx);
    logic [V-1:0] l;
    logic [7:0]   b;
    b = 8'(idx) ^ 8'h3C;
    if (idx == 2) b = 8'hA5;
    for (int i = 0; i < BW; i++) l[8*i +: 8] = b;
    return l;
  endfunction

  function automatic logic [V-1:0] merge(input logic [V-1:0] old_l, input logic [V-1:0] new_l,
                                         input logic [BW-1:0] be);
    logic [V-1:0] l;
    l = old_l;
    for (int i = 0; i < BW; i++) if (be[i]) l[8*i +: 8] = new_l[8*i +: 8];
    return l;
  endfunction

  // RAM model: byte-masked writes, RD_LAT-cycle read pipeline; junk when idle
  logic [V-1:0] ram_mem [NLINES];
  logic [V-1:0] rd_pipe [RD_LAT];
  logic         load_init;
  assign ram_q = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (load_init) begin
      for (int i = 0; i < NLINES; i++) ram_mem[i] <= init_line(i);
    end else if (ram_wren) begin
      for (int b = 0; b < BW; b++)
        if (ram_byteena[b]) ram_mem[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
    end
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= ram_rden ? ram_mem[ram_address] : rand_line();
  end

  // Reference model: expected RAM contents and last read line
  logic [V-1:0] ref_mem [NLINES];
  logic [V-1:0] last_rd;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [V-1:0]  data;
    int            exp_busy;
    int            exp_rp;
    int            exp_wp;
  } vec_t;

  // Called just after a rising edge; request is held through the DONE cycle,
  // then dropped just after the following edge.
  task automatic run_access(input vec_t v);
    logic [LW-1:0] line;
    logic [V-1:0]  exp_rd;
    bit            is_rd;
    int            busy_cnt, rp, wp, both;
    bit            done;
    line   = v.addr[AW-1:5];
    is_rd  = v.rd && !v.wr;
    exp_rd = is_rd ? ref_mem[line] : last_rd;
    MemRden = v.rd; MemWren = v.wr; MemAddress = v.addr;
    MemByteena = v.be; MemWriteData = v.data;
    busy_cnt = 0; rp = 0; wp = 0; both = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (ram_rden && ram_wren) both++;
      if (ram_wren) begin
        wp++;
        chk("wr_address", V'(ram_address), V'(line));
        chk("wr_data", ram_data, v.data);
        chk("wr_byteena", V'(ram_byteena), V'(v.be));
      end
      if (ram_rden) begin
        rp++;
        chk("rd_address", V'(ram_address), V'(line));
        chk("rd_byteena", V'(ram_byteena), V'({BW{1'b1}}));
      end
      if (BusyDA) busy_cnt++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    chk("completed", V'(done), V'(1));
    chk("busy_cycles", V'(busy_cnt), V'(v.exp_busy));
    chk("rden_pulses", V'(rp), V'(v.exp_rp));
    chk("wren_pulses", V'(wp), V'(v.exp_wp));
    chk("strobe_overlap", V'(both), V'(0));
    chk("read_data", MemReadData, exp_rd);
    if (v.wr) ref_mem[line] = merge(ref_mem[line], v.data, v.be);
    if (is_rd) last_rd = exp_rd;
    @(posedge clk);
    #1;
    MemRden = 1'b0; MemWren = 1'b0;
  endtask

  vec_t tbl [9];
  vec_t rv;
  logic [V-1:0] asc, dead;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < BW; i++) asc[8*i +: 8] = 8'(i + 1);
    dead = {{7{32'h11111111}}, 32'hDEADBEEF};
    tbl[0] = '{1'b1, 1'b0, 14'h0040, '1,            '0,   RD_LAT + 2, 1, 0};
    tbl[1] = '{1'b0, 1'b1, 14'h0040, 32'hFFFFFFFF,  asc,  2,          0, 1};
    tbl[2] = '{1'b1, 1'b0, 14'h0040, '0,            '0,   RD_LAT + 2, 1, 0};
    tbl[3] = '{1'b0, 1'b1, 14'h0060, 32'h0000000F,  dead, 2,          0, 1};
    tbl[4] = '{1'b1, 1'b0, 14'h0060, '0,            '0,   RD_LAT + 2, 1, 0};
    tbl[5] = '{1'b1, 1'b1, 14'h0080, 32'h00FF00FF,  asc,  2,          0, 1};
    tbl[6] = '{1'b0, 1'b1, 14'h0060, 32'h00000000,  asc,  2,          0, 1};
    tbl[7] = '{1'b1, 1'b0, 14'h007F, '0,            '0,   RD_LAT + 2, 1, 0};
    tbl[8] = '{1'b1, 1'b0, 14'h3FFF, '0,            '0,   RD_LAT + 2, 1, 0};

    for (int i = 0; i < NLINES; i++) ref_mem[i] = init_line(i);
    last_rd = '0;
    rst = 1'b1; load_init = 1'b1;
    MemRden = 1'b0; MemWren = 1'b0; MemAddress = '0; MemByteena = '0; MemWriteData = '0;

    // Reset then idle
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_busy", V'(BusyDA), V'(0));
      chk("rst_strobes", V'({ram_rden, ram_wren}), V'(0));
      chk("rst_rdata", MemReadData, '0);
      chk("rst_ram_regs", {ram_data[V-1:BW+LW], ram_byteena, ram_address}, '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; load_init = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("idle_busy", V'(BusyDA), V'(0));
      chk("idle_strobes", V'({ram_rden, ram_wren}), V'(0));
      chk("idle_rdata", MemReadData, '0);
    end
    @(posedge clk);
    #1;

    // Directed table, accesses issued back-to-back
    for (int i = 0; i < 9; i++) run_access(tbl[i]);
    chk("partial_low_word", V'(ref_mem[3][31:0]), V'(32'hDEADBEEF));

    // Read data holds after the request drops, no re-acceptance
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("hold_busy", V'(BusyDA), V'(0));
      chk("hold_strobes", V'({ram_rden, ram_wren}), V'(0));
      chk("hold_rdata", MemReadData, last_rd);
      @(posedge clk);
      #1;
    end

    // Reset during WAIT
    MemRden = 1'b1; MemAddress = 14'h0040;
    @(negedge clk);
    chk("rw_req_busy", V'(BusyDA), V'(1));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1; MemRden = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_rd = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rw_busy", V'(BusyDA), V'(0));
      chk("rw_strobes", V'({ram_rden, ram_wren}), V'(0));
      chk("rw_rdata", MemReadData, '0);
      @(posedge clk);
      #1;
    end

    // Randomized accesses against the reference model
    for (int n = 0; n < 60; n++) begin
      rv.rd   = ($urandom_range(0, 2) != 0);
      rv.wr   = ($urandom_range(0, 2) == 0);
      rv.addr = AW'($urandom);
      if ($urandom_range(0, 1) == 1) rv.addr[AW-1:9] = '0;
      case ($urandom_range(0, 3))
        0:       rv.be = '0;
        1:       rv.be = '1;
        default: rv.be = BW'($urandom);
      endcase
      rv.data     = rand_line();
      rv.exp_busy = rv.wr ? 2 : (rv.rd ? RD_LAT + 2 : 0);
      rv.exp_rp   = (rv.rd && !rv.wr) ? 1 : 0;
      rv.exp_wp   = rv.wr ? 1 : 0;
      run_access(rv);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
